// File: rtl/div_defs_pkg.sv
// Shared definitions for the restoring divider: default width and FSM encoding.
package div_defs;

  localparam int unsigned DEF_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division stage: shift the partial remainder left, bring in the
// next dividend bit, and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned W = 3
) (
  input  logic [W:0]   rem,
  input  logic         msb,
  input  logic [W-1:0] b,
  output logic [W:0]   new_rem_c,
  output logic         q_bit_c
);

  localparam int unsigned SW = W + 2;

  logic [SW-1:0] shifted_c;
  logic [SW-1:0] divisor_c;
  logic [SW-1:0] diff_c;
  logic          fits_c;

  // Shift/compare/subtract; the extra top bit keeps the compare exact.
  always_comb begin
    shifted_c = {rem, msb};
    divisor_c = SW'(b);
    diff_c    = shifted_c - divisor_c;
    fits_c    = (shifted_c >= divisor_c);
    q_bit_c   = fits_c;
    new_rem_c = fits_c ? (W + 1)'(diff_c) : (W + 1)'(shifted_c);
  end

endmodule

// File: rtl/three_bit_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first,
// with a fast path that reports divide-by-zero without iterating.
module three_bit_divider
  import div_defs::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned RW = W + 1;

  state_t        state;
  logic [RW-1:0] rem;
  // Holds the dividend; quotient bits shift in from the bottom as it drains.
  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          dbz_pend;

  logic [RW-1:0] step_rem_c;
  logic          step_qbit_c;

  // Single stage reused every CALC cycle.
  div_step #(
    .W(W)
  ) u_step (
    .rem       (rem),
    .msb       (dvd[W-1]),
    .b         (dvs),
    .new_rem_c (step_rem_c),
    .q_bit_c   (step_qbit_c)
  );

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      dbz_pend <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs <= b;
            cnt <= '0;
            if (b == '0) begin
              // Divide-by-zero result is preloaded so DONE handles both paths alike.
              rem      <= RW'(a);
              dvd      <= '1;
              dbz_pend <= 1'b1;
              state    <= DONE;
            end else begin
              rem      <= '0;
              dvd      <= a;
              dbz_pend <= 1'b0;
              busy     <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem <= step_rem_c;
          dvd <= W'({dvd, step_qbit_c});
          if (cnt == CW'(W - 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          q     <= dvd;
          r     <= rem[W-1:0];
          dbz   <= dbz_pend;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_three_bit_divider.sv
// Self-checking bench for three_bit_divider (W=3) against an arithmetic model.
module tb_three_bit_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] a;
  logic [2:0] b;
  logic [2:0] q;
  logic [2:0] r;
  logic       busy;
  logic       done;
  logic       dbz;

  int n_tests;
  int n_fail;
  int cyc;

  three_bit_divider #(.W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, all-ones quotient and r=a on divide-by-zero.
  function automatic int ref_q(input int x, input int y);
    return (y == 0) ? 7 : x / y;
  endfunction

  function automatic int ref_r(input int x, input int y);
    return (y == 0) ? x : x % y;
  endfunction

  function automatic int ref_lat(input int y);
    return (y == 0) ? 1 : 4;
  endfunction

  // Issue one division; reports edges from accept to done and busy cycles seen.
  task automatic do_op(input int ta, input int tb_v, input bit hold,
                       output int lat, output int busy_cycles);
    @(negedge clk);
    a     = 3'(ta);
    b     = 3'(tb_v);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat         = -1;
    busy_cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      if (hold && i == 2) begin
        a = 3'd1;
        b = 3'd1;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int ta, input int tb_v);
    check({tag, "_q"}, int'(q), ref_q(ta, tb_v));
    check({tag, "_r"}, int'(r), ref_r(ta, tb_v));
    check({tag, "_dbz"}, int'(dbz), (tb_v == 0) ? 1 : 0);
  endtask

  int lat;
  int bcy;
  int extra_done;
  int pairs[64];
  int prev_done;
  int found;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    #1;
    check("reset_q", int'(q), 0);
    check("reset_r", int'(r), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_dbz", int'(dbz), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 7/2: three busy cycles, done four edges after accept.
    do_op(7, 2, 1'b0, lat, bcy);
    check("d72_lat", lat, 4);
    check("d72_busy", bcy, 3);
    check_result("d72", 7, 2);

    // 5/0 goes straight to DONE, then 6/3 clears dbz.
    do_op(5, 0, 1'b0, lat, bcy);
    check("d50_lat", lat, 1);
    check("d50_busy", bcy, 0);
    check_result("d50", 5, 0);
    do_op(6, 3, 1'b0, lat, bcy);
    check("d63_lat", lat, 4);
    check_result("d63", 6, 3);

    // Start held and operands changed mid-CALC: ignored, single done.
    do_op(6, 3, 1'b1, lat, bcy);
    check("hold_lat", lat, 4);
    check_result("hold", 6, 3);
    extra_done = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    check("hold_extra_done", extra_done, 0);

    // Reset during the second CALC cycle of 7/1 aborts with no done.
    @(negedge clk);
    a     = 3'd7;
    b     = 3'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_q", int'(q), 0);
    check("abort_r", int'(r), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_dbz", int'(dbz), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    check("abort_no_done", extra_done, 0);
    do_op(7, 1, 1'b0, lat, bcy);
    check("d71_lat", lat, 4);
    check_result("d71", 7, 1);

    // Random operations, optionally holding start, with an idle gap afterwards.
    for (int k = 0; k < 30; k++) begin
      int ta, tbv, gap;
      ta  = int'($urandom_range(7, 0));
      tbv = int'($urandom_range(7, 0));
      gap = int'($urandom_range(3, 0));
      do_op(ta, tbv, 1'($urandom_range(1, 0)), lat, bcy);
      check("rnd_lat", lat, ref_lat(tbv));
      check_result("rnd", ta, tbv);
      repeat (gap) @(posedge clk);
      #1;
      check("rnd_hold_q", int'(q), ref_q(ta, tbv));
      check("rnd_hold_r", int'(r), ref_r(ta, tbv));
    end

    // All 64 pairs in random order, each issued in the cycle right after done.
    for (int i = 0; i < 64; i++) pairs[i] = i;
    for (int i = 63; i > 0; i--) begin
      int j, t;
      j        = int'($urandom_range(i, 0));
      t        = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = t;
    end
    @(negedge clk);
    a         = 3'(pairs[0] / 8);
    b         = 3'(pairs[0] % 8);
    start     = 1'b1;
    prev_done = -1;
    for (int k = 0; k < 64; k++) begin
      int ta, tbv;
      ta  = pairs[k] / 8;
      tbv = pairs[k] % 8;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) begin
          found = 1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("sweep_done", found, 1);
      check_result("sweep", ta, tbv);
      if (prev_done >= 0)
        check("sweep_spacing", cyc - prev_done, ref_lat(tbv) + 1);
      prev_done = cyc;
      if (k < 63) begin
        a     = 3'(pairs[k + 1] / 8);
        b     = 3'(pairs[k + 1] % 8);
        start = 1'b1;
      end
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
